// File: rtl/mem_bus_pkg.sv
// Shared command encodings and arbiter state type for the memory bus.
// The core's data-memory stage imports the same command constants.
package mem_bus_pkg;

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_READ  = 3'd1;
    localparam logic [2:0] CMD_WRITE = 3'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2
    } arb_state_t;

    // Only reads and writes are real commands; every other code means "nothing".
    function automatic logic is_data_cmd(input logic [2:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRITE);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the instruction-fetch and data ports.
// One transaction outstanding at a time; data wins unless a waiting fetch
// has already been passed over STARVE_LIMIT times in a row.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_start,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_inst,
    output logic        i_valid,

    input  logic [2:0]  d_cmd,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [31:0] d_wmask,
    output logic        d_cmd_ready,
    output logic [31:0] d_rdata,
    output logic        d_rdata_valid,

    output logic [2:0]  mem_cmd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_wmask,
    input  logic        mem_cmd_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_valid
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_next;

    logic data_req;
    logic fetch_forced;
    logic grant_data;
    logic grant_fetch;
    logic data_accept;
    logic fetch_accept;

    // Read data is shared by both requesters; the valid pulses say whose it is.
    assign i_inst  = mem_rdata;
    assign d_rdata = mem_rdata;

    // Grant decision, recomputed every IDLE cycle from the live request lines.
    always_comb begin
        data_req     = is_data_cmd(d_cmd);
        fetch_forced = (starve_cnt == CNT_MAX) && i_start;
        grant_data   = 1'b0;
        grant_fetch  = 1'b0;
        if (!reset && (state == IDLE)) begin
            if (data_req && !fetch_forced) begin
                grant_data = 1'b1;
            end else if (i_start) begin
                grant_fetch = 1'b1;
            end
        end
        data_accept  = grant_data && mem_cmd_ready;
        fetch_accept = grant_fetch && mem_cmd_ready;
    end

    // Downstream command mux, handshakes, response routing and next state.
    always_comb begin
        state_next    = state;
        mem_cmd       = CMD_NONE;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wmask     = '0;
        i_ready       = 1'b0;
        d_cmd_ready   = 1'b0;
        i_valid       = 1'b0;
        d_rdata_valid = 1'b0;

        if (reset) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        mem_cmd     = d_cmd;
                        mem_addr    = d_addr;
                        mem_wdata   = d_wdata;
                        mem_wmask   = d_wmask;
                        d_cmd_ready = mem_cmd_ready;
                        if (data_accept && (d_cmd == CMD_READ)) begin
                            state_next = D_WAIT;
                        end
                    end else if (grant_fetch) begin
                        mem_cmd  = CMD_READ;
                        mem_addr = i_addr;
                        i_ready  = mem_cmd_ready;
                        if (fetch_accept) begin
                            state_next = I_WAIT;
                        end
                    end
                end
                I_WAIT: begin
                    if (mem_rdata_valid) begin
                        i_valid    = 1'b1;
                        state_next = IDLE;
                    end
                end
                D_WAIT: begin
                    if (mem_rdata_valid) begin
                        d_rdata_valid = 1'b1;
                        state_next    = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Starvation counter: counts data grants that jumped a waiting fetch.
    always_comb begin
        starve_cnt_next = starve_cnt;
        if (!i_start || fetch_accept) begin
            starve_cnt_next = '0;
        end else if (data_accept && (starve_cnt != CNT_MAX)) begin
            starve_cnt_next = starve_cnt + CNT_W'(1);
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_mem_bus_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        i_start;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_inst;
    logic        i_valid;
    logic [2:0]  d_cmd;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_wmask;
    logic        d_cmd_ready;
    logic [31:0] d_rdata;
    logic        d_rdata_valid;
    logic [2:0]  mem_cmd;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_wmask;
    logic        mem_cmd_ready;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;

    int n_checks = 0;
    int n_fails  = 0;

    // Model: 0 = free, 1 = fetch read outstanding, 2 = data read outstanding.
    int m_busy = 0;
    int m_skips = 0;
    bit m_i_acc = 0;
    bit m_d_acc = 0;
    bit m_rd_acc = 0;

    mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_start        (i_start),
        .i_addr         (i_addr),
        .i_ready        (i_ready),
        .i_inst         (i_inst),
        .i_valid        (i_valid),
        .d_cmd          (d_cmd),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_wmask        (d_wmask),
        .d_cmd_ready    (d_cmd_ready),
        .d_rdata        (d_rdata),
        .d_rdata_valid  (d_rdata_valid),
        .mem_cmd        (mem_cmd),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_cmd_ready  (mem_cmd_ready),
        .mem_rdata      (mem_rdata),
        .mem_rdata_valid(mem_rdata_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive every input just after a rising edge.
    task automatic apply_stimulus(input bit rst, input bit is, input logic [31:0] ia,
                                  input logic [2:0] dc, input logic [31:0] da,
                                  input logic [31:0] dw, input logic [31:0] dm,
                                  input bit mr, input bit rv, input logic [31:0] rd);
        @(posedge clk);
        #1;
        reset           = rst;
        i_start         = is;
        i_addr          = ia;
        d_cmd           = dc;
        d_addr          = da;
        d_wdata         = dw;
        d_wmask         = dm;
        mem_cmd_ready   = mr;
        mem_rdata_valid = rv;
        mem_rdata       = rd;
    endtask

    // Behavioural reference: every cycle, work out what the arbiter must
    // present from the request lines and whether a read is outstanding.
    always @(negedge clk) begin
        bit          e_iready, e_dready, e_ivalid, e_dvalid;
        logic [2:0]  e_cmd;
        logic [31:0] e_addr, e_wdata, e_wmask;
        bit          data_wants, fetch_due;
        int          busy_after, skips_after;

        e_iready = 0; e_dready = 0; e_ivalid = 0; e_dvalid = 0;
        e_cmd = 3'd0; e_addr = 32'd0; e_wdata = 32'd0; e_wmask = 32'd0;
        m_i_acc = 0; m_d_acc = 0; m_rd_acc = 0;
        busy_after = m_busy;
        skips_after = m_skips;

        if (reset) begin
            busy_after = 0;
            skips_after = 0;
        end else begin
            if (m_busy == 0) begin
                data_wants = (d_cmd == 3'd1) || (d_cmd == 3'd2);
                fetch_due  = i_start && (m_skips >= LIMIT);
                if (data_wants && !fetch_due) begin
                    e_cmd = d_cmd; e_addr = d_addr; e_wdata = d_wdata; e_wmask = d_wmask;
                    e_dready = mem_cmd_ready;
                    m_d_acc = mem_cmd_ready;
                    if (m_d_acc && d_cmd == 3'd1) begin
                        busy_after = 2;
                        m_rd_acc = 1;
                    end
                end else if (i_start) begin
                    e_cmd = 3'd1; e_addr = i_addr;
                    e_iready = mem_cmd_ready;
                    m_i_acc = mem_cmd_ready;
                    if (m_i_acc) begin
                        busy_after = 1;
                        m_rd_acc = 1;
                    end
                end
            end else if (mem_rdata_valid) begin
                e_ivalid = (m_busy == 1);
                e_dvalid = (m_busy == 2);
                busy_after = 0;
            end
            if (!i_start || m_i_acc) skips_after = 0;
            else if (m_d_acc && m_skips < LIMIT) skips_after = m_skips + 1;
        end

        check_output("i_ready", {31'd0, i_ready}, {31'd0, e_iready});
        check_output("d_cmd_ready", {31'd0, d_cmd_ready}, {31'd0, e_dready});
        check_output("i_valid", {31'd0, i_valid}, {31'd0, e_ivalid});
        check_output("d_rdata_valid", {31'd0, d_rdata_valid}, {31'd0, e_dvalid});
        check_output("mem_cmd", {29'd0, mem_cmd}, {29'd0, e_cmd});
        if (e_cmd != 3'd0) check_output("mem_addr", mem_addr, e_addr);
        if (e_cmd == 3'd2) begin
            check_output("mem_wdata", mem_wdata, e_wdata);
            check_output("mem_wmask", mem_wmask, e_wmask);
        end
        if (e_ivalid) check_output("i_inst", i_inst, mem_rdata);
        if (e_dvalid) check_output("d_rdata", d_rdata, mem_rdata);

        m_busy  = busy_after;
        m_skips = skips_after;
    end

    initial begin
        int resp_cnt;
        reset = 1'b1; i_start = 0; i_addr = 0; d_cmd = 0; d_addr = 0; d_wdata = 0;
        d_wmask = 0; mem_cmd_ready = 0; mem_rdata_valid = 0; mem_rdata = 0;

        // Reset forces outputs idle even with live requests and a stray response.
        apply_stimulus(1, 1, 32'h10, 3'd1, 32'h20, 0, 0, 1, 1, 32'h5);
        @(negedge clk);
        check_output("rst i_ready", {31'd0, i_ready}, 32'd0);
        check_output("rst d_cmd_ready", {31'd0, d_cmd_ready}, 32'd0);
        check_output("rst mem_cmd", {29'd0, mem_cmd}, 32'd0);
        check_output("rst valids", {30'd0, i_valid, d_rdata_valid}, 32'd0);
        apply_stimulus(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);

        // Lone fetch, memory latency 2.
        apply_stimulus(0, 1, 32'h100, 3'd0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        check_output("fetch i_ready", {31'd0, i_ready}, 32'd1);
        check_output("fetch mem_addr", mem_addr, 32'h100);
        apply_stimulus(0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        check_output("fetch wait cmd", {29'd0, mem_cmd}, 32'd0);
        apply_stimulus(0, 0, 0, 3'd0, 0, 0, 0, 1, 1, 32'h13);
        @(negedge clk);
        check_output("fetch i_valid", {31'd0, i_valid}, 32'd1);
        check_output("fetch i_inst", i_inst, 32'h13);
        apply_stimulus(0, 1, 32'h104, 3'd0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("fetch back idle", {29'd0, mem_cmd}, 32'd1);
        apply_stimulus(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);

        // Fetch and data read together: data first, fetch after the response.
        apply_stimulus(0, 1, 32'h300, 3'd1, 32'h2000, 0, 0, 1, 0, 0);
        @(negedge clk);
        check_output("conflict mem_addr", mem_addr, 32'h2000);
        check_output("conflict i_ready", {31'd0, i_ready}, 32'd0);
        apply_stimulus(0, 1, 32'h300, 3'd0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        check_output("conflict wait cmd", {29'd0, mem_cmd}, 32'd0);
        apply_stimulus(0, 1, 32'h300, 3'd0, 0, 0, 0, 1, 1, 32'hCAFEF00D);
        @(negedge clk);
        check_output("conflict d_rdata_valid", {31'd0, d_rdata_valid}, 32'd1);
        check_output("conflict d_rdata", d_rdata, 32'hCAFEF00D);
        check_output("conflict resp cmd", {29'd0, mem_cmd}, 32'd0);
        apply_stimulus(0, 1, 32'h300, 3'd0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        check_output("conflict fetch ready", {31'd0, i_ready}, 32'd1);
        check_output("conflict fetch addr", mem_addr, 32'h300);
        apply_stimulus(0, 0, 0, 3'd0, 0, 0, 0, 1, 1, 32'h22);
        @(negedge clk);
        check_output("conflict i_valid", {31'd0, i_valid}, 32'd1);

        // Continuous writes against a waiting fetch: four writes, then the fetch.
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(0, 1, 32'h500, 3'd2, 32'h600 + 32'(4 * k), 32'(k), 32'hFFFFFFFF, 1, 0, 0);
            @(negedge clk);
            if (k < 4) check_output("starve write ready", {31'd0, d_cmd_ready}, 32'd1);
            else check_output("starve fetch ready", {31'd0, i_ready}, 32'd1);
        end
        apply_stimulus(0, 0, 0, 3'd0, 0, 0, 0, 1, 1, 32'h33);
        @(negedge clk);
        check_output("starve i_valid", {31'd0, i_valid}, 32'd1);
        apply_stimulus(0, 1, 32'h504, 3'd2, 32'h700, 32'h1, 32'h1, 1, 0, 0);
        @(negedge clk);
        check_output("starve cleared", {31'd0, d_cmd_ready}, 32'd1);
        apply_stimulus(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);

        // Write pass-through with memory stalling three cycles.
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(0, 0, 0, 3'd2, 32'h40, 32'hDEADBEEF, 32'h0000FFFF, k == 3, 0, 0);
            @(negedge clk);
            check_output("wr mem_cmd", {29'd0, mem_cmd}, 32'd2);
            check_output("wr mem_addr", mem_addr, 32'h40);
            check_output("wr mem_wdata", mem_wdata, 32'hDEADBEEF);
            check_output("wr mem_wmask", mem_wmask, 32'h0000FFFF);
            check_output("wr d_cmd_ready", {31'd0, d_cmd_ready}, (k == 3) ? 32'd1 : 32'd0);
        end

        // Reset while a fetch is outstanding; its late response is dropped.
        apply_stimulus(0, 1, 32'h800, 3'd0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        check_output("rmid accept", {31'd0, i_ready}, 32'd1);
        apply_stimulus(1, 0, 0, 3'd0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        check_output("rmid reset cmd", {29'd0, mem_cmd}, 32'd0);
        apply_stimulus(0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 0);
        apply_stimulus(0, 0, 0, 3'd0, 0, 0, 0, 1, 1, 32'h99);
        @(negedge clk);
        check_output("rmid late i_valid", {31'd0, i_valid}, 32'd0);
        check_output("rmid late d_valid", {31'd0, d_rdata_valid}, 32'd0);
        apply_stimulus(0, 1, 32'h900, 3'd0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("rmid idle grant", mem_addr, 32'h900);

        // Spurious response in IDLE.
        apply_stimulus(0, 0, 0, 3'd0, 0, 0, 0, 1, 1, 32'h1234);
        @(negedge clk);
        check_output("spurious valids", {30'd0, i_valid, d_rdata_valid}, 32'd0);

        // Randomized traffic; requesters hold until accepted, memory answers
        // reads after 1-3 cycles and occasionally sends stray responses.
        resp_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 199) == 0);
            mem_rdata_valid = 1'b0;
            mem_rdata = $urandom;
            if (m_rd_acc) resp_cnt = $urandom_range(1, 3);
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) mem_rdata_valid = 1'b1;
            end else if (m_busy == 0 && $urandom_range(0, 7) == 0) begin
                mem_rdata_valid = 1'b1;
            end
            if (!(i_start && !m_i_acc)) begin
                i_start = $urandom_range(0, 1);
                i_addr = $urandom & 32'hFFFFFFFC;
            end
            if (!((d_cmd == 3'd1 || d_cmd == 3'd2) && !m_d_acc)) begin
                d_cmd = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                d_addr = $urandom;
                d_wdata = $urandom;
                d_wmask = $urandom;
            end
            mem_cmd_ready = ($urandom_range(0, 3) != 0);
        end

        apply_stimulus(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
